// File: rtl/flreq_bank.sv
// flreq_bank: per-floor cabin and hall-call request latches plus a
// sweep-direction scheduler and nearest-target encoder for an N-floor lift.
// Every state update is qualified by the slow reference tick.
module flreq_bank #(
  parameter int NFLOORS = 8,
  parameter int FLW     = 3
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               slowref,
  input  logic [NFLOORS-1:0] sw_pulse,
  input  logic [NFLOORS-1:0] up_pulse,
  input  logic [NFLOORS-1:0] dn_pulse,
  input  logic               clr_flreq,
  input  logic [FLW-1:0]     clr_idx,
  input  logic [FLW-1:0]     cur_floor,
  output logic [NFLOORS-1:0] flreq_led,
  output logic [NFLOORS-1:0] up_led,
  output logic [NFLOORS-1:0] dn_led,
  output logic [1:0]         sched_dir,
  output logic               req_here,
  output logic               req_above,
  output logic               req_below,
  output logic [FLW-1:0]     next_floor,
  output logic               next_valid
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } dir_t;

  localparam logic [31:0] NF = 32'(NFLOORS);
  // The top floor has no up-call button and the bottom floor no down-call.
  localparam logic [NFLOORS-1:0] UP_KEEP = ~(NFLOORS'(1) << (NFLOORS - 1));
  localparam logic [NFLOORS-1:0] DN_KEEP = ~NFLOORS'(1);

  logic [NFLOORS-1:0] flreq_reg, flreq_next;
  logic [NFLOORS-1:0] up_reg, up_next;
  logic [NFLOORS-1:0] dn_reg, dn_next;
  dir_t               dir_reg, dir_next;

  logic [NFLOORS-1:0] any_req;
  logic [NFLOORS-1:0] above_mask, below_mask, here_mask, clr_mask;
  logic [NFLOORS-1:0] above_hits, below_hits;
  logic [NFLOORS-1:0] up_clr, dn_clr;
  logic               cur_valid, clr_valid;
  logic [FLW-1:0]     up_pick, dn_pick;

  assign cur_valid = (32'(cur_floor) < NF);
  assign clr_valid = (32'(clr_idx) < NF);

  // Per-floor position masks relative to the cabin and the clear decode.
  // An out-of-range cur_floor is treated as "above every floor".
  for (genvar gi = 0; gi < NFLOORS; gi++) begin : g_mask
    localparam logic [FLW-1:0] IDX = FLW'(gi);
    assign above_mask[gi] = cur_valid && (cur_floor < IDX);
    assign below_mask[gi] = !cur_valid || (cur_floor > IDX);
    assign here_mask[gi]  = cur_valid && (cur_floor == IDX);
    assign clr_mask[gi]   = clr_flreq && clr_valid && (clr_idx == IDX);
  end

  assign any_req    = flreq_reg | up_reg | dn_reg;
  assign above_hits = any_req & above_mask;
  assign below_hits = any_req & below_mask;
  assign req_here   = |(any_req & here_mask);
  assign req_above  = |above_hits;
  assign req_below  = |below_hits;

  // Hall-call clears follow the sweep: only the call in the travel direction
  // is served; in IDLE both are served.
  assign up_clr = (dir_reg == S_DOWN) ? '0 : clr_mask;
  assign dn_clr = (dir_reg == S_UP)   ? '0 : clr_mask;

  // Latch next-state: set from pulses, then clear wins on the same bit.
  always_comb begin
    flreq_next = (flreq_reg | sw_pulse) & ~clr_mask;
    up_next    = (up_reg | up_pulse) & ~up_clr & UP_KEEP;
    dn_next    = (dn_reg | dn_pulse) & ~dn_clr & DN_KEEP;
  end

  // Request latches and sweep state, updated only on slowref.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      flreq_reg <= '0;
      up_reg    <= '0;
      dn_reg    <= '0;
      dir_reg   <= S_IDLE;
    end else if (slowref) begin
      flreq_reg <= flreq_next;
      up_reg    <= up_next;
      dn_reg    <= dn_next;
      dir_reg   <= dir_next;
    end
  end

  // Sweep direction: keep going while work remains ahead, else reverse, else idle.
  always_comb begin
    dir_next = dir_reg;
    unique case (dir_reg)
      S_IDLE: begin
        if (req_above)      dir_next = S_UP;
        else if (req_below) dir_next = S_DOWN;
        else                dir_next = S_IDLE;
      end
      S_UP: begin
        if (req_above)      dir_next = S_UP;
        else if (req_below) dir_next = S_DOWN;
        else                dir_next = S_IDLE;
      end
      S_DOWN: begin
        if (req_below)      dir_next = S_DOWN;
        else if (req_above) dir_next = S_UP;
        else                dir_next = S_IDLE;
      end
      default: dir_next = S_IDLE;
    endcase
  end

  // Nearest request above (lowest index) and below (highest index).
  always_comb begin
    up_pick = '0;
    dn_pick = '0;
    for (int i = NFLOORS - 1; i >= 0; i--) begin
      if (above_hits[i]) up_pick = FLW'(i);
    end
    for (int i = 0; i < NFLOORS; i++) begin
      if (below_hits[i]) dn_pick = FLW'(i);
    end
  end

  // Target selection for the current sweep; forced to 0 when not valid.
  always_comb begin
    next_floor = '0;
    next_valid = 1'b0;
    unique case (dir_reg)
      S_UP: begin
        next_valid = req_above;
        next_floor = req_above ? up_pick : '0;
      end
      S_DOWN: begin
        next_valid = req_below;
        next_floor = req_below ? dn_pick : '0;
      end
      default: begin
        next_valid = req_here;
        next_floor = req_here ? cur_floor : '0;
      end
    endcase
  end

  assign flreq_led = flreq_reg;
  assign up_led    = up_reg;
  assign dn_led    = dn_reg;
  assign sched_dir = dir_reg;

endmodule

// File: tb/tb_flreq_bank.sv
// Directed self-checking bench for flreq_bank (8 floors).
module tb_flreq_bank;

  logic       clk = 1'b0;
  logic       resetb;
  logic       slowref;
  logic [7:0] sw_pulse, up_pulse, dn_pulse;
  logic       clr_flreq;
  logic [2:0] clr_idx, cur_floor;
  logic [7:0] flreq_led, up_led, dn_led;
  logic [1:0] sched_dir;
  logic       req_here, req_above, req_below;
  logic [2:0] next_floor;
  logic       next_valid;

  int total = 0;
  int bad   = 0;

  flreq_bank #(.NFLOORS(8), .FLW(3)) dut (
    .clk       (clk),
    .resetb    (resetb),
    .slowref   (slowref),
    .sw_pulse  (sw_pulse),
    .up_pulse  (up_pulse),
    .dn_pulse  (dn_pulse),
    .clr_flreq (clr_flreq),
    .clr_idx   (clr_idx),
    .cur_floor (cur_floor),
    .flreq_led (flreq_led),
    .up_led    (up_led),
    .dn_led    (dn_led),
    .sched_dir (sched_dir),
    .req_here  (req_here),
    .req_above (req_above),
    .req_below (req_below),
    .next_floor(next_floor),
    .next_valid(next_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs, then pulses and clear return to idle.
  task automatic apply(input logic sr, input logic [7:0] sw, input logic [7:0] up,
                       input logic [7:0] dn, input logic clr, input logic [2:0] idx);
    slowref = sr; sw_pulse = sw; up_pulse = up; dn_pulse = dn;
    clr_flreq = clr; clr_idx = idx;
    tick();
    slowref = 1'b0; sw_pulse = '0; up_pulse = '0; dn_pulse = '0;
    clr_flreq = 1'b0; clr_idx = '0;
  endtask

  task automatic do_reset(input logic [2:0] cf);
    slowref = 1'b0; sw_pulse = '0; up_pulse = '0; dn_pulse = '0;
    clr_flreq = 1'b0; clr_idx = '0; cur_floor = cf;
    resetb = 1'b0;
    @(negedge clk);
    resetb = 1'b1;
    tick();
  endtask

  initial begin
    resetb = 1'b0; slowref = 1'b0; sw_pulse = '0; up_pulse = '0; dn_pulse = '0;
    clr_flreq = 1'b0; clr_idx = '0; cur_floor = '0;
    #12;
    chk("rst_flreq", 32'(flreq_led), 32'h00);
    chk("rst_up",    32'(up_led),    32'h00);
    chk("rst_dn",    32'(dn_led),    32'h00);
    chk("rst_dir",   32'(sched_dir), 32'h0);
    chk("rst_flags", 32'({req_here, req_above, req_below}), 32'h0);
    chk("rst_next",  32'({next_valid, next_floor}), 32'h0);

    // Single cabin request above the cabin.
    do_reset(3'd2);
    apply(1'b1, 8'h20, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("a_flreq",  32'(flreq_led), 32'h20);
    chk("a_dir0",   32'(sched_dir), 32'h0);
    chk("a_above",  32'(req_above), 32'h1);
    chk("a_nv0",    32'(next_valid), 32'h0);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("a_dir_up", 32'(sched_dir), 32'h1);
    chk("a_nf",     32'(next_floor), 32'h5);
    chk("a_nv",     32'(next_valid), 32'h1);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 3'd5);
    chk("a_clr_flreq", 32'(flreq_led), 32'h00);
    chk("a_clr_dir",   32'(sched_dir), 32'h1);
    chk("a_clr_next",  32'({next_valid, next_floor}), 32'h0);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("a_idle",   32'(sched_dir), 32'h0);

    // Pulse held with slowref low is ignored until slowref arrives.
    do_reset(3'd2);
    sw_pulse = 8'h08;
    repeat (10) tick();
    chk("b_hold",  32'(flreq_led), 32'h00);
    slowref = 1'b1;
    tick();
    slowref = 1'b0; sw_pulse = '0;
    chk("b_set",   32'(flreq_led), 32'h08);

    // Direction-aware hall clear.
    do_reset(3'd2);
    apply(1'b1, 8'h08, 8'h08, 8'h08, 1'b0, 3'd0);
    chk("c_up_set", 32'(up_led), 32'h08);
    chk("c_dn_set", 32'(dn_led), 32'h08);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("c_dir_up", 32'(sched_dir), 32'h1);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 3'd3);
    chk("c_flreq",  32'(flreq_led), 32'h00);
    chk("c_up_clr", 32'(up_led), 32'h00);
    chk("c_dn_keep", 32'(dn_led), 32'h08);
    chk("c_next",   32'({next_valid, next_floor}), 32'hB);
    cur_floor = 3'd3;
    #1;
    chk("c_here",   32'({req_here, req_above, req_below}), 32'h4);
    chk("c_nv_up",  32'(next_valid), 32'h0);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("c_dir_idle", 32'(sched_dir), 32'h0);
    chk("c_idle_next", 32'({next_valid, next_floor}), 32'hB);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 3'd3);
    chk("c_dn_clr", 32'(dn_led), 32'h00);

    // Clear versus set on the same and on different floors.
    do_reset(3'd0);
    apply(1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("d_set4",  32'(flreq_led), 32'h10);
    apply(1'b1, 8'h10, 8'h00, 8'h00, 1'b1, 3'd4);
    chk("d_clrwin", 32'(flreq_led), 32'h00);
    apply(1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 3'd0);
    apply(1'b1, 8'h40, 8'h00, 8'h00, 1'b1, 3'd4);
    chk("d_diff",  32'(flreq_led), 32'h40);

    // Two-sided sweep: floors 1 and 6 with the cabin at 4.
    do_reset(3'd4);
    apply(1'b1, 8'h42, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("e_dir0",  32'(sched_dir), 32'h0);
    chk("e_flags", 32'({req_here, req_above, req_below}), 32'h3);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("e_up",    32'(sched_dir), 32'h1);
    chk("e_nf6",   32'({next_valid, next_floor}), 32'hE);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 3'd6);
    chk("e_clr6",  32'(flreq_led), 32'h02);
    chk("e_up2",   32'(sched_dir), 32'h1);
    chk("e_nv0",   32'(next_valid), 32'h0);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("e_down",  32'(sched_dir), 32'h2);
    chk("e_nf1",   32'({next_valid, next_floor}), 32'h9);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b1, 3'd1);
    chk("e_clr1",  32'(flreq_led), 32'h00);
    chk("e_down2", 32'(sched_dir), 32'h2);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("e_idle",  32'(sched_dir), 32'h0);
    chk("e_next0", 32'({next_valid, next_floor}), 32'h0);

    // Missing end-floor hall buttons, then asynchronous reset mid-sweep.
    do_reset(3'd0);
    apply(1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0, 3'd0);
    chk("f_up_top", 32'(up_led), 32'h7F);
    chk("f_dn_bot", 32'(dn_led), 32'hFE);
    apply(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0);
    chk("f_up",     32'(sched_dir), 32'h1);
    #2;
    resetb = 1'b0;
    #1;
    chk("f_arst_led", 32'({up_led, dn_led, flreq_led}), 32'h0);
    chk("f_arst_dir", 32'(sched_dir), 32'h0);
    chk("f_arst_out", 32'({req_here, req_above, req_below, next_valid, next_floor}), 32'h0);
    @(negedge clk);
    resetb = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
